weight_loader: RTL

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader_pkg.sv | 18 +
 rtl/weight_loader_if.sv | 22 ++
 rtl/weight_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/weight_loader_pkg.sv
// ---------------------------------------------------------------------------
// weight_loader_pkg
//   Shared types for the weight loader: the session state encoding.
//   Holds no parameters; sizing lives on the weight_loader module itself.
// ---------------------------------------------------------------------------
package weight_loader_pkg;

    // Session phases: wait for start, stream words into memory, let the last
    // registered write reach the bus, read everything back, report result.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        FLUSH  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } loader_state_t;

endpackage : weight_loader_pkg

// File: rtl/weight_loader_if.sv
// ---------------------------------------------------------------------------
// weight_loader_if
//   Upstream weight stream handshake into the loader.
//   data_i  : weight word from the upstream stream
//   valid_i : data_i is valid
//   ready_o : loader accepts data_i this cycle
//   modport master : upstream source (drives data_i/valid_i)
//   modport slave  : the loader (drives ready_o)
// ---------------------------------------------------------------------------
interface weight_loader_if #(
    parameter int WORD_SIZE = 16
);
    import weight_loader_pkg::*;

    logic [WORD_SIZE-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);

endinterface : weight_loader_if

// File: rtl/weight_loader.sv
// ---------------------------------------------------------------------------
// weight_loader
//   Streams DEPTH weight words into an external SRAM (addresses 0..DEPTH-1),
//   then reads them back and compares a modulo-2**WORD_SIZE checksum of the
//   read data against the checksum of the accepted words.
//
// Ports
//   clk_i        : clock, rising edge
//   reset_i      : synchronous active-high reset
//   start_i      : one-cycle pulse starting a session (IDLE or DONE only)
//   in_if        : weight stream (data_i / valid_i / ready_o), slave side
//   mem_addr_o   : SRAM address, registered
//   mem_data_o   : SRAM write data, registered
//   mem_wen_o    : SRAM write enable, active low, registered
//   mem_rdata_i  : SRAM read data, one cycle after the address
//   busy_o       : session in progress (WRITE, FLUSH, VERIFY)
//   done_o       : session complete, held until next start or reset
//   error_o      : readback checksum mismatch, valid with done_o
// ---------------------------------------------------------------------------
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int WORD_SIZE  = 16,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    weight_loader_if.slave        in_if,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0]  mem_data_o,
    output logic                  mem_wen_o,
    input  logic [WORD_SIZE-1:0]  mem_rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    // One extra bit so the counter can reach DEPTH when DEPTH == 2**ADDR_WIDTH.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] VERIFY_END = CNT_W'(DEPTH);

    loader_state_t        state;
    logic                 ready_q;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [WORD_SIZE-1:0] wsum;
    logic [WORD_SIZE-1:0] rsum;
    logic [WORD_SIZE-1:0] wsum_nxt;
    logic [WORD_SIZE-1:0] rsum_nxt;
    logic                 accept;

    assign in_if.ready_o = ready_q;
    assign accept        = in_if.valid_i && ready_q;
    assign cnt_nxt       = cnt + 1'b1;
    // Checksums wrap naturally at WORD_SIZE bits.
    assign wsum_nxt      = wsum + in_if.data_i;
    assign rsum_nxt      = rsum + mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // Forcing mem_wen_o high here also drops any write that was
            // accepted in the reset cycle.
            state      <= IDLE;
            ready_q    <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_wen_o  <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            cnt        <= '0;
            wsum       <= '0;
            rsum       <= '0;
        end else begin
            // A write strobe lasts exactly the one cycle after its accept.
            mem_wen_o <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state   <= WRITE;
                        ready_q <= 1'b1;
                        busy_o  <= 1'b1;
                        done_o  <= 1'b0;
                        error_o <= 1'b0;
                        cnt     <= '0;
                        wsum    <= '0;
                        rsum    <= '0;
                    end
                end

                WRITE: begin
                    if (accept) begin
                        mem_addr_o <= cnt[ADDR_WIDTH-1:0];
                        mem_data_o <= in_if.data_i;
                        mem_wen_o  <= 1'b0;
                        wsum       <= wsum_nxt;
                        cnt        <= cnt_nxt;
                        if (cnt == LAST_WORD) begin
                            ready_q <= 1'b0;
                            state   <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    // Final write is on the bus this cycle; line up read
                    // address 0 for the first VERIFY cycle.
                    mem_addr_o <= '0;
                    cnt        <= '0;
                    state      <= VERIFY;
                end

                VERIFY: begin
                    // cnt counts VERIFY cycles; read data for address cnt-1
                    // arrives in cycle cnt, so cycle 0 has nothing to sum.
                    if (cnt != '0) begin
                        rsum <= rsum_nxt;
                    end
                    if (cnt == VERIFY_END) begin
                        state   <= DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        error_o <= (rsum_nxt != wsum);
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt != VERIFY_END) begin
                            mem_addr_o <= cnt_nxt[ADDR_WIDTH-1:0];
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule : weight_loader
